// File: rtl/conv_pe_accum_engine.sv
// 3x3 convolution PE: accumulates one output map over several input channels into a
// local result buffer, then drains it as a post-processed valid/ready pixel stream.
module conv_pe_accum_engine #(
    parameter int PIXEL_WIDTH  = 16,
    parameter int KERNEL_WIDTH = 16,
    parameter int RESULT_WIDTH = 48,
    parameter int DEPTH        = 16384,
    parameter int ADDR_WIDTH   = 14,
    parameter int CH_WIDTH     = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    input  logic [ADDR_WIDTH:0]       cfg_num_pixels,
    input  logic [CH_WIDTH-1:0]       cfg_num_ch,
    input  logic [5:0]                cfg_shift,
    input  logic                      cfg_relu,
    input  logic [RESULT_WIDTH-1:0]   bias,
    input  logic                      kernel_wr,
    input  logic [9*KERNEL_WIDTH-1:0] kernel_flat,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [9*PIXEL_WIDTH-1:0]  in_window,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [PIXEL_WIDTH-1:0]    out_data,
    output logic                      out_last,
    output logic                      done
);
    localparam int PROD_WIDTH = PIXEL_WIDTH + KERNEL_WIDTH;
    localparam logic [ADDR_WIDTH:0]  PIX_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [CH_WIDTH-1:0]  CH_ONE  = {{(CH_WIDTH-1){1'b0}}, 1'b1};
    localparam logic signed [RESULT_WIDTH-1:0] SAT_MAX =
        {{(RESULT_WIDTH-PIXEL_WIDTH+1){1'b0}}, {(PIXEL_WIDTH-1){1'b1}}};
    localparam logic signed [RESULT_WIDTH-1:0] SAT_MIN =
        {{(RESULT_WIDTH-PIXEL_WIDTH+1){1'b1}}, {(PIXEL_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, FLUSH = 2'd2, DRAIN = 2'd3} state_t;

    function automatic logic [PROD_WIDTH-1:0] smul(input logic [PIXEL_WIDTH-1:0] x,
                                                   input logic [KERNEL_WIDTH-1:0] k);
        logic signed [PROD_WIDTH-1:0] xe;
        logic signed [PROD_WIDTH-1:0] ke;
        xe = PROD_WIDTH'($signed(x));
        ke = PROD_WIDTH'($signed(k));
        return xe * ke;
    endfunction

    function automatic logic [PIXEL_WIDTH-1:0] post_proc(input logic [RESULT_WIDTH-1:0] w_in,
                                                         input logic relu,
                                                         input logic [5:0] sh);
        logic signed [RESULT_WIDTH-1:0] w;
        w = $signed(w_in);
        if (relu && w[RESULT_WIDTH-1]) begin
            w = {RESULT_WIDTH{1'b0}};
        end else begin
            w = w;
        end
        w = w >>> sh;
        if (w > SAT_MAX) begin
            return SAT_MAX[PIXEL_WIDTH-1:0];
        end else if (w < SAT_MIN) begin
            return SAT_MIN[PIXEL_WIDTH-1:0];
        end else begin
            return w[PIXEL_WIDTH-1:0];
        end
    endfunction

    state_t                    state_r;
    logic [ADDR_WIDTH:0]       num_pixels_r;
    logic [CH_WIDTH-1:0]       num_ch_r;
    logic [5:0]                shift_r;
    logic                      relu_r;
    logic [RESULT_WIDTH-1:0]   bias_r;
    logic [9*KERNEL_WIDTH-1:0] kernel_r;
    logic [ADDR_WIDTH:0]       pix_r;
    logic [CH_WIDTH-1:0]       ch_r;

    logic                      s1_valid_r;
    logic                      s1_first_r;
    logic [ADDR_WIDTH-1:0]     s1_addr_r;
    logic [PROD_WIDTH-1:0]     prod_r [9];
    logic [PROD_WIDTH-1:0]     prod_s [9];
    logic                      s2_valid_r;
    logic [ADDR_WIDTH-1:0]     s2_addr_r;
    logic [RESULT_WIDTH-1:0]   s2_sum_r;
    logic [RESULT_WIDTH-1:0]   sum_s;

    logic [RESULT_WIDTH-1:0]   mem_r [DEPTH];
    logic [RESULT_WIDTH-1:0]   rd_data_r;
    logic [ADDR_WIDTH:0]       rd_ptr_r;
    logic                      a_valid_r;
    logic                      a_last_r;
    logic                      out_valid_r;
    logic [PIXEL_WIDTH-1:0]    out_data_r;
    logic                      out_last_r;
    logic                      done_r;

    logic                      hazard_s;
    logic                      in_ready_s;
    logic                      accept_s;
    logic                      b_load_s;
    logic                      a_adv_s;
    logic                      issue_s;
    logic                      rd_en_s;
    logic [ADDR_WIDTH-1:0]     rd_addr_s;

    // Handshake decode: no forwarding, so a re-read of an address still in flight must stall
    always_comb begin
        hazard_s   = (ch_r != {CH_WIDTH{1'b0}}) &&
                     ((s1_valid_r && (s1_addr_r == pix_r[ADDR_WIDTH-1:0])) ||
                      (s2_valid_r && (s2_addr_r == pix_r[ADDR_WIDTH-1:0])));
        in_ready_s = (state_r == ACCUM) && !hazard_s;
        accept_s   = in_valid && in_ready_s;
        b_load_s   = !out_valid_r || out_ready;
        a_adv_s    = a_valid_r && b_load_s;
        issue_s    = (state_r == DRAIN) && (rd_ptr_r < num_pixels_r) && (!a_valid_r || a_adv_s);
        rd_en_s    = accept_s || issue_s;
        if (state_r == DRAIN) begin
            rd_addr_s = rd_ptr_r[ADDR_WIDTH-1:0];
        end else begin
            rd_addr_s = pix_r[ADDR_WIDTH-1:0];
        end
    end

    // Stage-1 products against the current kernel register
    always_comb begin
        for (int j = 0; j < 9; j++) begin
            prod_s[j] = smul(in_window[(8-j)*PIXEL_WIDTH +: PIXEL_WIDTH],
                             kernel_r[(8-j)*KERNEL_WIDTH +: KERNEL_WIDTH]);
        end
    end

    // Stage-2 adder tree: bias seeds the first channel, buffer data seeds later ones
    always_comb begin
        if (s1_first_r) begin
            sum_s = bias_r;
        end else begin
            sum_s = rd_data_r;
        end
        for (int j = 0; j < 9; j++) begin
            sum_s = sum_s + {{(RESULT_WIDTH-PROD_WIDTH){prod_r[j][PROD_WIDTH-1]}}, prod_r[j]};
        end
    end

    // Result buffer: contents survive reset, writes still in flight at reset are dropped
    always_ff @(posedge clk) begin
        if (s2_valid_r && !rst) begin
            mem_r[s2_addr_r] <= s2_sum_r;
        end
        if (rd_en_s) begin
            rd_data_r <= mem_r[rd_addr_s];
        end
    end

    // Control FSM, MAC pipeline registers and drain output stage
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            num_pixels_r <= {(ADDR_WIDTH+1){1'b0}};
            num_ch_r     <= {CH_WIDTH{1'b0}};
            shift_r      <= 6'd0;
            relu_r       <= 1'b0;
            bias_r       <= {RESULT_WIDTH{1'b0}};
            kernel_r     <= {(9*KERNEL_WIDTH){1'b0}};
            pix_r        <= {(ADDR_WIDTH+1){1'b0}};
            ch_r         <= {CH_WIDTH{1'b0}};
            s1_valid_r   <= 1'b0;
            s1_first_r   <= 1'b0;
            s1_addr_r    <= {ADDR_WIDTH{1'b0}};
            for (int j = 0; j < 9; j++) begin
                prod_r[j] <= {PROD_WIDTH{1'b0}};
            end
            s2_valid_r   <= 1'b0;
            s2_addr_r    <= {ADDR_WIDTH{1'b0}};
            s2_sum_r     <= {RESULT_WIDTH{1'b0}};
            rd_ptr_r     <= {(ADDR_WIDTH+1){1'b0}};
            a_valid_r    <= 1'b0;
            a_last_r     <= 1'b0;
            out_valid_r  <= 1'b0;
            out_data_r   <= {PIXEL_WIDTH{1'b0}};
            out_last_r   <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            if (kernel_wr) begin
                kernel_r <= kernel_flat;
            end
            done_r     <= 1'b0;
            s1_valid_r <= accept_s;
            s1_first_r <= (ch_r == {CH_WIDTH{1'b0}});
            s1_addr_r  <= pix_r[ADDR_WIDTH-1:0];
            prod_r     <= prod_s;
            s2_valid_r <= s1_valid_r;
            s2_addr_r  <= s1_addr_r;
            s2_sum_r   <= sum_s;

            // Read-data register doubles as the skid slot ahead of the output register
            if (issue_s) begin
                rd_ptr_r  <= rd_ptr_r + PIX_ONE;
                a_valid_r <= 1'b1;
                a_last_r  <= (rd_ptr_r == num_pixels_r - PIX_ONE);
            end else if (a_adv_s) begin
                a_valid_r <= 1'b0;
            end
            if (b_load_s) begin
                out_valid_r <= a_valid_r;
                out_last_r  <= a_valid_r && a_last_r;
                if (a_valid_r) begin
                    out_data_r <= post_proc(rd_data_r, relu_r, shift_r);
                end
            end

            case (state_r)
                IDLE: begin
                    if (cfg_valid) begin
                        num_pixels_r <= cfg_num_pixels;
                        num_ch_r     <= cfg_num_ch;
                        shift_r      <= cfg_shift;
                        relu_r       <= cfg_relu;
                        bias_r       <= bias;
                        pix_r        <= {(ADDR_WIDTH+1){1'b0}};
                        ch_r         <= {CH_WIDTH{1'b0}};
                        rd_ptr_r     <= {(ADDR_WIDTH+1){1'b0}};
                        state_r      <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (accept_s) begin
                        if (pix_r == num_pixels_r - PIX_ONE) begin
                            pix_r <= {(ADDR_WIDTH+1){1'b0}};
                            if (ch_r == num_ch_r - CH_ONE) begin
                                state_r <= FLUSH;
                            end else begin
                                ch_r <= ch_r + CH_ONE;
                            end
                        end else begin
                            pix_r <= pix_r + PIX_ONE;
                        end
                    end
                end
                FLUSH: begin
                    if (!s1_valid_r && !s2_valid_r) begin
                        state_r <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (out_valid_r && out_ready && out_last_r) begin
                        done_r  <= 1'b1;
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign cfg_ready = (state_r == IDLE);
    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_last  = out_last_r;
    assign done      = done_r;
endmodule

// File: tb/tb_conv_pe_accum_engine.sv
// Directed bench for conv_pe_accum_engine: a per-pixel accumulation model predicts every
// drained beat, plus literal expectations for the hand-computed scenarios.
module tb_conv_pe_accum_engine;
    localparam int PW = 16, KW = 16, RW = 48, DEPTH = 16384, AW = 14, CW = 10;

    logic clk = 1'b0, rst = 1'b1;
    logic cfg_valid = 1'b0, cfg_ready, cfg_relu = 1'b0, kernel_wr = 1'b0;
    logic [AW:0] cfg_num_pixels = '0;
    logic [CW-1:0] cfg_num_ch = '0;
    logic [5:0] cfg_shift = '0;
    logic [RW-1:0] bias = '0;
    logic [9*KW-1:0] kernel_flat = '0;
    logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, out_last, done;
    logic [9*PW-1:0] in_window = '0;
    logic [PW-1:0] out_data;

    always #5 clk = ~clk;

    conv_pe_accum_engine #(.PIXEL_WIDTH(PW), .KERNEL_WIDTH(KW), .RESULT_WIDTH(RW),
                           .DEPTH(DEPTH), .ADDR_WIDTH(AW), .CH_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_num_pixels(cfg_num_pixels), .cfg_num_ch(cfg_num_ch), .cfg_shift(cfg_shift),
        .cfg_relu(cfg_relu), .bias(bias), .kernel_wr(kernel_wr), .kernel_flat(kernel_flat),
        .in_valid(in_valid), .in_ready(in_ready), .in_window(in_window),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .done(done));

    int pass_cnt = 0, total_cnt = 0, cyc_cnt = 0, ready_mode = 0, last_cnt = 0;
    int kern[9], kern_next[9], pix_tbl[0:63];
    longint acc[0:63];
    longint cur_bias;
    int cur_shift;
    bit cur_relu;
    longint exp_q[$], got_q[$];
    bit exp_last_q[$];
    int accept_cyc[$];

    task automatic check(input string name, input longint act, input longint expv);
        total_cnt++;
        if (act == expv) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    endtask

    // Model of the drain arithmetic: 48-bit wrap, optional ReLU, floor shift, clamp
    function automatic longint post(input longint w_in);
        longint w;
        w = (w_in <<< 16) >>> 16;
        if (cur_relu && w < 0) w = 0;
        w = w >>> cur_shift;
        if (w > 32767) w = 32767;
        else if (w < -32768) w = -32768;
        return w;
    endfunction

    function automatic logic [9*KW-1:0] pack_k();
        logic [9*KW-1:0] v;
        for (int j = 0; j < 9; j++) v[(8-j)*KW +: KW] = KW'(kern_next[j]);
        return v;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc_cnt++;
    end

    initial forever begin
        @(posedge clk);
        #1;
        out_ready = (ready_mode == 0) ? 1'b1 : ($urandom_range(0, 9) < 3);
    end

    // Output monitor: every beat against the model, hold-while-stalled, done timing
    initial begin
        bit stall_prev, hs_last_prev;
        logic [PW-1:0] held_data;
        logic held_last;
        stall_prev = 0;
        hs_last_prev = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_prev = 0;
                hs_last_prev = 0;
            end else begin
                if (stall_prev)
                    check("hold_stable", (out_valid && out_data == held_data && out_last == held_last), 1);
                if (out_valid && out_ready) begin
                    got_q.push_back(longint'($signed(out_data)));
                    if (out_last) last_cnt++;
                    if (exp_q.size() == 0) begin
                        check("unexpected_beat", 1, 0);
                    end else begin
                        check("beat_data", longint'($signed(out_data)), exp_q.pop_front());
                        check("beat_last", out_last, exp_last_q.pop_front());
                    end
                end
                if (done || hs_last_prev) check("done_timing", done, hs_last_prev);
                stall_prev = out_valid && !out_ready;
                held_data = out_data;
                held_last = out_last;
                hs_last_prev = out_valid && out_ready && out_last;
            end
        end
    end

    task automatic apply_kernel();
        kernel_flat = pack_k();
        kernel_wr = 1'b1;
        @(posedge clk);
        #1;
        kernel_wr = 1'b0;
        kern = kern_next;
    endtask

    task automatic send_cfg(input int np, input int nch, input longint b, input int sh, input bit relu);
        bit got;
        int w;
        cfg_num_pixels = (AW+1)'(np);
        cfg_num_ch = CW'(nch);
        cfg_shift = 6'(sh);
        cfg_relu = relu;
        bias = RW'(b);
        cur_bias = b;
        cur_shift = sh;
        cur_relu = relu;
        cfg_valid = 1'b1;
        got = 0;
        w = 0;
        while (!got && w < 100) begin
            @(negedge clk);
            got = cfg_ready;
            @(posedge clk);
            #1;
            w++;
        end
        cfg_valid = 1'b0;
        if (!got) check("cfg_timeout", 0, 1);
    endtask

    // One window: mode 0 all=fill, mode 1 x00=pix_tbl[p], mode 2 random small values
    task automatic feed_one(input int ch, input int p, input int mode, input int fill,
                            input bit swap, output bit ok);
        int x[9];
        longint dot;
        int waited;
        for (int j = 0; j < 9; j++) begin
            if (mode == 0) x[j] = fill;
            else if (mode == 1) x[j] = (j == 0) ? pix_tbl[p] : 0;
            else x[j] = int'($urandom_range(0, 15)) - 8;
            in_window[(8-j)*PW +: PW] = PW'(x[j]);
        end
        in_valid = 1'b1;
        if (swap) begin
            kernel_flat = pack_k();
            kernel_wr = 1'b1;
        end
        ok = 0;
        waited = 0;
        while (!ok && waited < 50) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                dot = 0;
                for (int j = 0; j < 9; j++) dot += longint'(x[j]) * kern[j];
                acc[p] = ((ch == 0) ? cur_bias : acc[p]) + dot;
                accept_cyc.push_back(cyc_cnt);
            end
            @(posedge clk);
            #1;
            if (kernel_wr) begin
                kernel_wr = 1'b0;
                kern = kern_next;
            end
            waited++;
        end
        in_valid = 1'b0;
        if (!ok) check("accept_timeout", 0, 1);
    endtask

    task automatic run_job(input int np, input int nch, input longint b, input int sh, input bit relu,
                           input int mode, input int fill, input int swap_at);
        bit ok, seen;
        int w;
        got_q.delete();
        accept_cyc.delete();
        last_cnt = 0;
        send_cfg(np, nch, b, sh, relu);
        for (int c = 0; c < nch; c++)
            for (int p = 0; p < np; p++) begin
                feed_one(c, p, mode, fill, (c * np + p) == swap_at, ok);
                if (!ok) return;
            end
        for (int p = 0; p < np; p++) begin
            exp_q.push_back(post(acc[p]));
            exp_last_q.push_back(p == np - 1);
        end
        seen = 0;
        w = 0;
        while (!seen && w < 3000) begin
            @(negedge clk);
            seen = done;
            w++;
        end
        check("done_seen", seen, 1);
        check("beats_left", exp_q.size(), 0);
        check("beat_count", got_q.size(), np);
        check("last_count", last_cnt, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        kern = '{default: 0};
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cfg_ready", cfg_ready, 1);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_done", done, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        kern_next = '{default: 1};
        apply_kernel();

        // Abort mid-accumulation
        send_cfg(8, 1, 0, 0, 0);
        for (int p = 0; p < 5; p++) feed_one(0, p, 0, 2, 0, ok);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        kern = '{default: 0};
        @(negedge clk);
        check("abort_cfg_ready", cfg_ready, 1);
        check("abort_in_ready", in_ready, 0);
        check("abort_out_valid", out_valid, 0);
        check("abort_done", done, 0);
        @(posedge clk);
        #1;
        apply_kernel();

        // Bias on one channel: 100 + 9*2
        run_job(4, 1, 100, 0, 0, 0, 2, -1);
        for (int i = 0; i < 4; i++) check("bias_lit", got_q[i], 118);

        // Three channels of ones: -5 + 3*9, full rate with no hazard stalls
        run_job(16, 3, -5, 0, 0, 0, 1, -1);
        for (int i = 0; i < 16; i++) check("multich_lit", got_q[i], 22);
        check("multich_rate", accept_cyc[47] - accept_cyc[0], 47);

        // Single pixel, four channels: interlock spaces accepts, 7 + 4*27
        run_job(1, 4, 7, 0, 0, 0, 3, -1);
        check("hazard_lit", got_q[0], 115);
        for (int i = 1; i < 4; i++) check("hazard_gap", (accept_cyc[i] - accept_cyc[i-1]) >= 3, 1);

        // Post-processing with results -70000, 70000, 300
        kern_next = '{100, 0, 0, 0, 0, 0, 0, 0, 0};
        apply_kernel();
        pix_tbl[0] = -700;
        pix_tbl[1] = 700;
        pix_tbl[2] = 3;
        run_job(3, 1, 0, 2, 1, 1, 0, -1);
        check("pp_relu0", got_q[0], 0);
        check("pp_relu1", got_q[1], 17500);
        check("pp_relu2", got_q[2], 75);
        run_job(3, 1, 0, 0, 0, 1, 0, -1);
        check("pp_sat0", got_q[0], -32768);
        check("pp_sat1", got_q[1], 32767);
        check("pp_sat2", got_q[2], 300);

        // Backpressure with random windows and a kernel change mid-accumulation
        kern_next = '{default: 1};
        apply_kernel();
        kern_next = '{2, -1, 3, 0, 1, -2, 1, 1, 4};
        ready_mode = 1;
        run_job(64, 2, 1234, 3, 0, 2, 0, 70);
        ready_mode = 0;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
